display_serializer: RTL

//  Downstream of the control block. Takes its registered display outputs: six ASCII

---
 rtl/display_serializer.sv | 101 ++++++++++
 1 files changed

// File: rtl/display_serializer.sv
// display_serializer: sends each changed (or refreshed) display image as a 9-byte SPI mode-0 frame.
module display_serializer #(
    parameter int CLK_DIV = 4,
    parameter logic [7:0] FRAME_START = 8'hA5,
    parameter int GAP_CYCLES = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] lower0001,
    input  logic [7:0] lower0010,
    input  logic [7:0] lower0100,
    input  logic [7:0] lower1000,
    input  logic [7:0] upper01,
    input  logic [7:0] upper10,
    input  logic       AVS,
    input  logic       DAY,
    input  logic       MAX,
    input  logic       TIM,
    input  logic       col,
    input  logic       point,
    input  logic       refresh,
    output logic       lcd_cs_n,
    output logic       lcd_sclk,
    output logic       lcd_mosi,
    output logic       busy,
    output logic       frame_done
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    state_t state;
    logic [7:0] flags, checksum;
    logic [55:0] image, shadow;
    logic [71:0] shreg;
    logic [6:0] bit_cnt;
    logic [15:0] div_cnt, gap_cnt;
    logic pending, changed;
    assign flags = {AVS, DAY, MAX, TIM, col, point, 2'b00};
    assign image = {upper10, upper01, lower1000, lower0100, lower0010, lower0001, flags};
    assign checksum = upper10 ^ upper01 ^ lower1000 ^ lower0100 ^ lower0010 ^ lower0001 ^ flags;
    assign changed = image != shadow;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            lcd_cs_n <= 1'b1;
            lcd_sclk <= 1'b0;
            lcd_mosi <= 1'b0;
            busy <= 1'b0;
            frame_done <= 1'b0;
            shadow <= '0;
            pending <= 1'b1;
            shreg <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            frame_done <= 1'b0;
            pending <= (state == LOAD) ? 1'b0 : pending | refresh | changed;
            case (state)
                IDLE: if (pending | refresh | changed) begin
                    state <= LOAD;
                    busy <= 1'b1;
                end
                // the snapshot is taken here, so a change arriving in this cycle is included
                LOAD: begin
                    shadow <= image;
                    shreg <= {FRAME_START, image, checksum};
                    lcd_cs_n <= 1'b0;
                    lcd_mosi <= FRAME_START[7];
                    bit_cnt <= '0;
                    div_cnt <= '0;
                    state <= SHIFT;
                end
                SHIFT: if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    lcd_sclk <= ~lcd_sclk;
                    if (lcd_sclk && bit_cnt == 7'd71) begin
                        lcd_cs_n <= 1'b1;
                        lcd_mosi <= 1'b0;
                        frame_done <= 1'b1;
                        gap_cnt <= '0;
                        state <= GAP;
                    end else if (lcd_sclk) begin
                        shreg <= {shreg[70:0], 1'b0};
                        lcd_mosi <= shreg[70];
                        bit_cnt <= bit_cnt + 7'd1;
                    end
                end else begin
                    div_cnt <= div_cnt + 16'd1;
                end
                GAP: if (gap_cnt == GAP_LAST) begin
                    state <= IDLE;
                    busy <= 1'b0;
                end else begin
                    gap_cnt <= gap_cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
